// File: rtl/logic_control.sv
// Microwave control logic: synchronises the front-panel, door and timer inputs
// and drives mutually exclusive, fail-safe Set/Reset commands to the magnetron latch.
module logic_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic S,
  output logic R
);

  // Bit order: {startn, stopn, clearn, door_closed, timer_done}; safe = buttons
  // released, door open, timer idle, which keeps the magnetron off after reset.
  localparam logic [4:0] SAFE_VALUE = 5'b11100;

  logic [4:0] rawIn;
  logic [4:0] syncChain_q [SYNC_STAGES];
  logic [4:0] syncOut;

  logic startn_s;
  logic stopn_s;
  logic clearn_s;
  logic door_closed_s;
  logic timer_done_s;

  logic sNext_d;
  logic rNext_d;
  logic sOut_q;
  logic rOut_q;

  assign rawIn = {startn, stopn, clearn, door_closed, timer_done};

  always_ff @(posedge clk) begin
    if (rst) begin
      syncChain_q[0] <= SAFE_VALUE;
    end else begin
      syncChain_q[0] <= rawIn;
    end
  end

  for (genvar g = 1; g < SYNC_STAGES; g++) begin : gSyncStage
    always_ff @(posedge clk) begin
      if (rst) begin
        syncChain_q[g] <= SAFE_VALUE;
      end else begin
        syncChain_q[g] <= syncChain_q[g-1];
      end
    end
  end

  assign syncOut = syncChain_q[SYNC_STAGES-1];
  assign {startn_s, stopn_s, clearn_s, door_closed_s, timer_done_s} = syncOut;

  // Any stop condition wins outright; S is masked so both commands can never be high.
  always_comb begin
    rNext_d = ~door_closed_s | ~stopn_s | ~clearn_s | timer_done_s;
    sNext_d = ~startn_s & door_closed_s & ~timer_done_s & ~rNext_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sOut_q <= 1'b0;
      rOut_q <= 1'b1;
    end else begin
      sOut_q <= sNext_d;
      rOut_q <= rNext_d;
    end
  end

  assign S = sOut_q;
  assign R = rOut_q;

endmodule

// File: tb/tb_logic_control.sv
// Directed and table-driven bench for logic_control at the default synchroniser depth.
module tb_logic_control;

  localparam int LAT = 3;

  logic clk;
  logic rst;
  logic startn;
  logic stopn;
  logic clearn;
  logic door_closed;
  logic timer_done;
  logic S;
  logic R;

  int errorCount;
  int checkCount;

  typedef struct {
    logic [4:0] in;
    logic       expS;
    logic       expR;
  } vec_t;

  vec_t table_v [12];

  logic [4:0] cur;
  logic [4:0] p0;
  logic [4:0] p1;
  logic [4:0] p2;
  logic       mS;
  logic       mR;

  logic_control #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .startn(startn),
    .stopn(stopn),
    .clearn(clearn),
    .door_closed(door_closed),
    .timer_done(timer_done),
    .S(S),
    .R(R)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs packed as {startn, stopn, clearn, door_closed, timer_done}.
  task automatic applyStimulus(input logic [4:0] v);
    {startn, stopn, clearn, door_closed, timer_done} = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic expS, input logic expR);
    checkCount++;
    if (S !== expS || R !== expR) begin
      errorCount++;
      $display("[TB] FAIL %s: got S=%b R=%b, expected S=%b R=%b", name, S, R, expS, expR);
    end
  endtask

  task automatic checkExclusive(input string name);
    checkCount++;
    if ((S & R) !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s: got S=%b R=%b, expected not both high", name, S, R);
    end
  endtask

  // Reference decode of the controller equations on a packed input vector.
  task automatic model(input logic [4:0] v, output logic es, output logic er);
    logic sn, stn, cn, dc, td;
    {sn, stn, cn, dc, td} = v;
    er = ~dc | ~stn | ~cn | td;
    es = ~sn & dc & ~td & ~er;
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;

    table_v[0]  = '{5'b11110, 1'b0, 1'b0};
    table_v[1]  = '{5'b01110, 1'b1, 1'b0};
    table_v[2]  = '{5'b11110, 1'b0, 1'b0};
    table_v[3]  = '{5'b10010, 1'b0, 1'b1};
    table_v[4]  = '{5'b00110, 1'b0, 1'b1};
    table_v[5]  = '{5'b01010, 1'b0, 1'b1};
    table_v[6]  = '{5'b01100, 1'b0, 1'b1};
    table_v[7]  = '{5'b01110, 1'b1, 1'b0};
    table_v[8]  = '{5'b01111, 1'b0, 1'b1};
    table_v[9]  = '{5'b11111, 1'b0, 1'b1};
    table_v[10] = '{5'b11101, 1'b0, 1'b1};
    table_v[11] = '{5'b01110, 1'b1, 1'b0};

    // Reset held with a start-while-closed pattern that would otherwise cook.
    rst = 1'b1;
    applyStimulus(5'b01110);
    tick(1);
    checkOutput("reset_edge1", 1'b0, 1'b1);
    tick(1);
    checkOutput("reset_edge2", 1'b0, 1'b1);

    rst = 1'b0;
    applyStimulus(5'b11110);
    tick(1);
    checkOutput("post_reset_edge1", 1'b0, 1'b1);
    tick(1);
    checkOutput("post_reset_edge2", 1'b0, 1'b1);
    tick(1);
    checkOutput("post_reset_idle", 1'b0, 1'b0);

    // Exact latency of a start press and its release.
    applyStimulus(5'b01110);
    tick(1);
    checkOutput("start_edge1", 1'b0, 1'b0);
    tick(1);
    checkOutput("start_edge2", 1'b0, 1'b0);
    tick(1);
    checkOutput("start_edge3", 1'b1, 1'b0);
    applyStimulus(5'b11110);
    tick(2);
    checkOutput("release_edge2", 1'b1, 1'b0);
    tick(1);
    checkOutput("release_edge3", 1'b0, 1'b0);

    // Door closing while start is held: latency into cooking.
    applyStimulus(5'b01100);
    tick(LAT);
    checkOutput("door_open", 1'b0, 1'b1);
    applyStimulus(5'b01110);
    tick(2);
    checkOutput("door_close_edge2", 1'b0, 1'b1);
    tick(1);
    checkOutput("door_close_edge3", 1'b1, 1'b0);

    // Timer expiry while cooking.
    applyStimulus(5'b01111);
    tick(2);
    checkOutput("timer_edge2", 1'b1, 1'b0);
    tick(1);
    checkOutput("timer_edge3", 1'b0, 1'b1);

    // Table of steady-state vectors, exclusivity checked on every cycle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(table_v[i].in);
      for (int c = 0; c < LAT; c++) begin
        tick(1);
        checkExclusive($sformatf("table%0d_excl%0d", i, c));
      end
      checkOutput($sformatf("table%0d", i), table_v[i].expS, table_v[i].expR);
    end

    // Reset asserted while cooking forces the latch off at the next edge.
    applyStimulus(5'b01110);
    tick(LAT);
    checkOutput("cook_before_rst", 1'b1, 1'b0);
    rst = 1'b1;
    tick(1);
    checkOutput("midop_rst", 1'b0, 1'b1);
    rst = 1'b0;
    tick(LAT + 1);
    checkOutput("midop_rst_recover", 1'b1, 1'b0);

    // Random sweep against a delayed reference model, with a reset pulse mid-way.
    cur = 5'b01110;
    p0 = cur;
    p1 = cur;
    p2 = cur;
    for (int v = 0; v < 32; v++) begin
      cur = 5'($urandom_range(0, 31));
      if (v == 16) begin
        applyStimulus(cur);
        rst = 1'b1;
        tick(1);
        checkOutput("sweep_rst", 1'b0, 1'b1);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
          tick(1);
          checkExclusive($sformatf("sweep_rst_excl%0d", c));
        end
        p0 = cur;
        p1 = cur;
        p2 = cur;
      end
      for (int c = 0; c < 6; c++) begin
        applyStimulus(cur);
        p2 = p1;
        p1 = p0;
        p0 = cur;
        tick(1);
        model(p2, mS, mR);
        checkOutput($sformatf("sweep%0d_c%0d", v, c), mS, mR);
        checkExclusive($sformatf("sweep%0d_excl%0d", v, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/logic_control.md
Name: logic_control

Overview:
- Control-logic block of the microwave controller.
- Takes the active-low front-panel buttons (start, stop, clear), the door switch and the cook-timer completion flag.
- Produces the Set (S) and Reset (R) commands for the downstream magnetron SR latch.
- Inputs are synchronised into the single clock domain; S and R are registered, mutually exclusive and fail-safe (R wins).

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each input synchroniser; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- startn  input  1  start button, active-low, asynchronous to clk.
- stopn  input  1  stop button, active-low, asynchronous to clk.
- clearn  input  1  clear button, active-low, asynchronous to clk.
- door_closed  input  1  door switch; 1 = door closed, asynchronous.
- timer_done  input  1  cook timer expired; 1 = done.
- S  output  1  set command to magnetron latch; active-high, registered.
- R  output  1  reset command to magnetron latch; active-high, registered.

Behaviour:
- Synchronisers:
  - Each of the five inputs passes through its own SYNC_STAGES-deep flop chain.
  - On rst, chains load inactive/safe values: startn=1, stopn=1, clearn=1, door_closed=0, timer_done=0.
- Combinational decode on synchronised values (suffix _s):
  - R_next = ~door_closed_s | ~stopn_s | ~clearn_s | timer_done_s
  - S_next = ~startn_s & door_closed_s & ~timer_done_s & ~R_next
- Priority: R dominates. S_next is forced 0 whenever R_next=1, so S and R are never both 1.
  - Example: pressing start while stop is held gives S=0, R=1.
- Output register:
  - S and R load S_next and R_next every clock.
  - No enable and no hold state; outputs follow the inputs.
- Latency: an input change meeting setup before edge k appears on S/R after edge k+SYNC_STAGES, i.e. 3 edges at the default.
- Reset:
  - While rst=1 at a clock edge: S=0, R=1 (latch held off).
  - Synchronisers load their safe values at the same edge.
  - After rst deasserts, R stays 1 until door_closed, stopn, clearn and timer_done have all been synchronised to their non-reset-causing values, i.e. at least SYNC_STAGES+1 edges.
  - rst asserted mid-operation forces S=0, R=1 at the next edge regardless of inputs.
- Idle case: all buttons released, door closed, timer not done gives S=0, R=0 (latch keeps its state).
- No glitches on S/R: both are driven directly from flops.
- Unknown or X inputs are not filtered. The synchronised value is used as-is once resolved.

Test Plan:
1. Reset check: rst=1 for 2 cycles with any inputs -> S=0, R=1. Release rst with startn=1, stopn=1, clearn=1, door_closed=1, timer_done=0 -> S=0, R=0 after 3 edges.
2. Start press: door_closed=1, timer_done=0, stopn=1, clearn=1, drive startn=0 -> S=1, R=0 exactly 3 edges later. Release startn=1 -> S=0, R=0 3 edges later.
3. Stop/clear dominance: startn=1, stopn=0, clearn=0, door_closed=1, timer_done=0 -> S=0, R=1. Then startn=0 with stopn=0 -> S=0, R=1; the outputs are never both 1.
4. Door open: startn=0, stopn=1, clearn=1, door_closed=0, timer_done=0 -> S=0, R=1. Closing the door (door_closed=1) -> S=1, R=0 after 3 edges.
5. Timer expiry: cooking state (startn=0, door_closed=1), then timer_done=1 -> S=0, R=1 after 3 edges.
6. Random sweep: 32 random 5-bit input vectors, each held 6 cycles -> S/R match the equations applied to inputs delayed SYNC_STAGES+1 edges. S&R==0 on every cycle. Mid-sweep rst pulse gives S=0, R=1 on the next edge.
